mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the unified word-addressed memory of the multi-cycle core.
- Shares the single memory port between instruction fetch (IF) and load/store (D).
- Latches the winning request and drives the memory's Address/Wdata/MemRead/MemWrite for exactly one cycle.
- Returns a registered response one cycle later.
- Flags misaligned or out-of-range accesses without touching memory.

Parameters:
- ADDR_W, 32, requester/memory address width
- DATA_W, 32, data width
- MEM_WORDS, 64, memory depth in words; byte addresses >= MEM_WORDS*4 are out of range

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately)
- if_req  in  1  fetch request; held with stable if_addr until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  one-cycle pulse: fetch request accepted and being performed
- if_rvalid  out  1  one-cycle pulse: fetch response valid
- if_rdata  out  DATA_W  fetched word, valid with if_rvalid
- if_err  out  1  fetch error, valid with if_rvalid
- d_req  in  1  data request; held with stable fields until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: data response (load data or store ack)
- d_rdata  out  DATA_W  load data; 0 for stores
- d_err  out  1  data error, valid with d_rvalid
- mem_addr  out  ADDR_W  to memory Address
- mem_wdata  out  DATA_W  to memory Wdata
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DATA_W  from memory Rdata (combinational read)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, last_grant = IF.
  - All outputs 0: gnt, rvalid, err, rdata, mem_* and busy.
  - Any in-flight request or response is dropped without a response.
  - A requester must re-issue its request after reset.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req, pick a winner, register its id/addr/we/wdata and go to ACCESS; else stay in IDLE.
  - ACCESS (exactly 1 cycle):
    - Assert the winner's gnt.
    - If the access is legal, drive mem_addr = latched addr, mem_read = !we, mem_write = we, and mem_wdata = wdata (0 for loads).
    - The memory commits the write on the negedge inside this cycle.
    - At the posedge ending ACCESS, capture mem_rdata for loads.
    - Next state is RESP.
  - RESP (1 cycle):
    - Assert the winner's rvalid with the registered rdata/err.
    - If any req is pending (the one just served is already deasserted by protocol), arbitrate and go to ACCESS; else go to IDLE.
- Latency: req high in IDLE at cycle N → gnt at N+1 → rvalid at N+2. Back-to-back throughput is 1 access per 2 cycles.
- Illegal access: addr[1:0] != 0 or addr >= MEM_WORDS*4.
  - mem_read and mem_write stay 0 during ACCESS.
  - rdata = 0 and err = 1 at RESP.
  - gnt is still issued.
- mem_* outputs are 0 in IDLE and RESP.
- gnt and rvalid are never asserted for both requesters in the same cycle.
- Arbitration (default): fixed priority, D over IF. D always wins simultaneous requests.
- Requester protocol violation (req dropped before gnt): the request may still be served; no special handling.
- Stores: d_rdata = 0, d_rvalid = 1.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous requests, grant the requester that did not win last_grant. last_grant updates on every grant. A continuously requesting pair alternates D, IF, D, IF.
- Undefined: fixed D-over-IF priority and last_grant is unused. IF can starve while D requests continuously; this is acceptable for the multi-cycle core.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - requester id enum {REQ_IF, REQ_D}
  - word-alignment mask constant
  - in-range check function using MEM_WORDS
- Sub-module arb_pick2: combinational two-input picker with inputs req_if, req_d, last_grant and output the winner id. Its round-robin logic is compiled under ARB_ROUND_ROBIN_EN.

Test Plan:
- Single load: d_req=1, d_we=0, d_addr=128, memory word 32 = 0xF → d_gnt at cycle 1, mem_read=1 with mem_addr=128 in cycle 1, d_rvalid at cycle 2 with d_rdata=0xF, d_err=0.
- Store then load: store 0x19 to 128, then load 128 → d_rvalid ack with rdata=0, then load returns 0x19; mem_write high for exactly one cycle.
- Simultaneous if_req (addr 0) and d_req (addr 132) → fixed priority: D first, IF second, with rvalids 2 cycles apart. With ARB_ROUND_ROBIN_EN and last_grant=D: IF first.
- Misaligned fetch if_addr=0x6 → if_gnt, mem_read and mem_write stay 0, if_rvalid with if_err=1 and if_rdata=0. Out-of-range d_addr=256 gives the same result on d_err.
- Reset mid-ACCESS: drop rst to 0 during ACCESS of a load → all outputs 0 immediately, no rvalid after rst=1, busy=0, next request served normally.
- Continuous requests from both for 8 accesses → no cycle has both gnts or both rvalids; round-robin build shows strict alternation.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and helpers for the memory arbiter slice.
// Holds the FSM state encoding, requester ids, the word-alignment mask
// and the in-range check against the memory depth.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_D  = 1'b1
   } req_id_t;

   // Low address bits that must be zero for a word access
   localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

   // True when a byte address falls inside a memory of mem_words words
   function automatic logic addr_in_range(input logic [63:0] byte_addr,
                                          input int unsigned mem_words);
      return byte_addr < (64'(mem_words) << 2);
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch requester, data requester and memory
// port signals. The slave modport is the arbiter's view; the master
// modport is the view of whatever surrounds it (requesters + memory).
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              if_err;
   // data requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              d_err;
   // memory port
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata, if_err,
      input  d_req, d_we, d_addr, d_wdata,
      output d_gnt, d_rvalid, d_rdata, d_err,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata, if_err,
      output d_req, d_we, d_addr, d_wdata,
      input  d_gnt, d_rvalid, d_rdata, d_err,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata
   );

endinterface

// File: rtl/arb_pick2.sv
// arb_pick2: combinational two-requester picker.
// Default build: fixed priority, data over fetch; last_grant is ignored.
// With ARB_ROUND_ROBIN_EN defined: on a tie, the requester that did not
// win last time is picked.
module arb_pick2
   import mem_arb_pkg::*;
(
   input  logic    req_if,
   input  logic    req_d,
   input  req_id_t last_grant,
   output req_id_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
   // Tie goes to whoever lost the previous grant
   always_comb begin
      winner = REQ_D;
      if (req_if && req_d) begin
         winner = (last_grant == REQ_D) ? REQ_IF : REQ_D;
      end else if (req_if) begin
         winner = REQ_IF;
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   // Data always wins; fetch only when data is not requesting
   always_comb begin
      winner = REQ_D;
      if (req_if && !req_d) begin
         winner = REQ_IF;
      end
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one word-addressed memory port between instruction
// fetch and load/store. A request is latched in IDLE/RESP, performed in a
// single ACCESS cycle and answered with a registered response in RESP.
// Misaligned or out-of-range accesses are granted and answered with err
// but never reach the memory.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin tie break).
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_WORDS = 64
)(
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus,
   output logic          busy
);

   state_t            state_reg;
   req_id_t           last_grant_reg;
   req_id_t           win_id_reg;
   logic              we_reg;
   logic              legal_reg;
   logic              busy_reg;

   logic              if_gnt_reg;
   logic              if_rvalid_reg;
   logic [DATA_W-1:0] if_rdata_reg;
   logic              if_err_reg;
   logic              d_gnt_reg;
   logic              d_rvalid_reg;
   logic [DATA_W-1:0] d_rdata_reg;
   logic              d_err_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic              mem_read_reg;
   logic              mem_write_reg;

   req_id_t           pick;
   logic              any_req;
   logic [ADDR_W-1:0] sel_addr;
   logic              sel_we;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_legal;

   arb_pick2 u_pick (
      .req_if     (bus.if_req),
      .req_d      (bus.d_req),
      .last_grant (last_grant_reg),
      .winner     (pick)
   );

   assign any_req = bus.if_req | bus.d_req;

   // Fields of the request that would win this cycle, plus its legality
   always_comb begin
      sel_addr  = bus.if_addr;
      sel_we    = 1'b0;
      sel_wdata = '0;
      if (pick == REQ_D) begin
         sel_addr  = bus.d_addr;
         sel_we    = bus.d_we;
         sel_wdata = bus.d_we ? bus.d_wdata : '0;
      end
      sel_legal = ((sel_addr[1:0] & WORD_ALIGN_MASK) == 2'b00) &&
                  addr_in_range(64'(sel_addr), $unsigned(MEM_WORDS));
   end

   // Sequencer FSM; every output is a register, pulses default to 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         last_grant_reg <= REQ_IF;
         win_id_reg     <= REQ_IF;
         we_reg         <= 1'b0;
         legal_reg      <= 1'b0;
         busy_reg       <= 1'b0;
         if_gnt_reg     <= 1'b0;
         if_rvalid_reg  <= 1'b0;
         if_rdata_reg   <= '0;
         if_err_reg     <= 1'b0;
         d_gnt_reg      <= 1'b0;
         d_rvalid_reg   <= 1'b0;
         d_rdata_reg    <= '0;
         d_err_reg      <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
      end else begin
         if_gnt_reg    <= 1'b0;
         if_rvalid_reg <= 1'b0;
         if_rdata_reg  <= '0;
         if_err_reg    <= 1'b0;
         d_gnt_reg     <= 1'b0;
         d_rvalid_reg  <= 1'b0;
         d_rdata_reg   <= '0;
         d_err_reg     <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;

         case (state_reg)
            // Both IDLE and RESP arbitrate; RESP's outputs were set on entry
            IDLE, RESP: begin
               if (any_req) begin
                  state_reg  <= ACCESS;
                  busy_reg   <= 1'b1;
                  win_id_reg <= pick;
                  we_reg     <= sel_we;
                  legal_reg  <= sel_legal;
                  if (pick == REQ_D) begin
                     d_gnt_reg <= 1'b1;
                  end else begin
                     if_gnt_reg <= 1'b1;
                  end
                  if (sel_legal) begin
                     mem_addr_reg  <= sel_addr;
                     mem_wdata_reg <= sel_wdata;
                     mem_read_reg  <= !sel_we;
                     mem_write_reg <= sel_we;
                  end
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant_reg <= pick;
`endif
               end else begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end
            end

            // Memory is being accessed; capture its read data for the response
            ACCESS: begin
               state_reg <= RESP;
               busy_reg  <= 1'b1;
               if (win_id_reg == REQ_D) begin
                  d_rvalid_reg <= 1'b1;
                  d_err_reg    <= !legal_reg;
                  d_rdata_reg  <= (legal_reg && !we_reg) ? bus.mem_rdata : '0;
               end else begin
                  if_rvalid_reg <= 1'b1;
                  if_err_reg    <= !legal_reg;
                  if_rdata_reg  <= legal_reg ? bus.mem_rdata : '0;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.if_gnt    = if_gnt_reg;
   assign bus.if_rvalid = if_rvalid_reg;
   assign bus.if_rdata  = if_rdata_reg;
   assign bus.if_err    = if_err_reg;
   assign bus.d_gnt     = d_gnt_reg;
   assign bus.d_rvalid  = d_rvalid_reg;
   assign bus.d_rdata   = d_rdata_reg;
   assign bus.d_err     = d_err_reg;
   assign bus.mem_addr  = mem_addr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.mem_read  = mem_read_reg;
   assign bus.mem_write = mem_write_reg;
   assign busy          = busy_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Responses are checked by a scoreboard (one queue per requester) filled
// when a request is issued; expected order for ties depends on
// ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;
   localparam int MEM_WORDS = 64;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic busy;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   exp_t        if_q[$];
   exp_t        d_q[$];
   logic [31:0] model [MEM_WORDS];
   logic [31:0] mem   [MEM_WORDS];
   bit          log_en = 1'b0;
   int          grant_cnt;
   logic [7:0]  grant_log;

   function automatic logic [31:0] init_word(input int i);
      return (i == 32) ? 32'h0000_000F : (32'hC0DE_0000 | 32'(i));
   endfunction

   // All arbiter outputs folded into one vector (all zero after reset)
   function automatic logic [12:0] outs_snapshot();
      return {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.if_err, bus.d_err,
              bus.mem_read, bus.mem_write, busy, |bus.if_rdata, |bus.d_rdata,
              |bus.mem_addr, |bus.mem_wdata};
   endfunction

   // Memory: combinational read, write committed on the negedge
   assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
   initial begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = init_word(i);
      forever begin
         @(negedge clk);
         if (bus.mem_write) mem[bus.mem_addr[7:2]] = bus.mem_wdata;
      end
   end

   // Monitor: exclusivity, grant order log and scoreboard pops
   always @(negedge clk) begin
      exp_t e;
      if (bus.if_gnt || bus.d_gnt || bus.if_rvalid || bus.d_rvalid) begin
         n_checks++;
         if ((bus.if_gnt && bus.d_gnt) || (bus.if_rvalid && bus.d_rvalid))
            $display("FAIL exclusive: gnt(if,d)=%b%b rvalid(if,d)=%b%b, expected at most one each",
                     bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid);
         else n_pass++;
      end
      if (!log_en) grant_cnt = 0;
      else if ((bus.if_gnt || bus.d_gnt) && grant_cnt < 8) begin
         grant_log[grant_cnt] = bus.d_gnt;
         grant_cnt++;
      end
      if (bus.d_rvalid) begin
         n_checks++;
         if (d_q.size() == 0)
            $display("FAIL d_resp: unexpected d_rvalid rdata=%h err=%b", bus.d_rdata, bus.d_err);
         else begin
            e = d_q.pop_front();
            if (bus.d_rdata !== e.rdata || bus.d_err !== e.err)
               $display("FAIL d_resp: got rdata=%h err=%b, expected rdata=%h err=%b",
                        bus.d_rdata, bus.d_err, e.rdata, e.err);
            else begin
               n_pass++;
               $display("d  resp rdata=%h err=%b ok", bus.d_rdata, bus.d_err);
            end
         end
      end
      if (bus.if_rvalid) begin
         n_checks++;
         if (if_q.size() == 0)
            $display("FAIL if_resp: unexpected if_rvalid rdata=%h err=%b", bus.if_rdata, bus.if_err);
         else begin
            e = if_q.pop_front();
            if (bus.if_rdata !== e.rdata || bus.if_err !== e.err)
               $display("FAIL if_resp: got rdata=%h err=%b, expected rdata=%h err=%b",
                        bus.if_rdata, bus.if_err, e.rdata, e.err);
            else begin
               n_pass++;
               $display("if resp rdata=%h err=%b ok", bus.if_rdata, bus.if_err);
            end
         end
      end
   end

   // Issue one data request; returns grant latency and memory-port snapshot
   task automatic d_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int cyc, output logic mr, output logic mw,
                          output logic [31:0] ma, output logic [31:0] mwd);
      exp_t e;
      logic legal;
      legal   = (addr[1:0] == 2'b00) && (addr < 32'(MEM_WORDS * 4));
      e.err   = !legal;
      e.rdata = (legal && !we) ? model[addr[7:2]] : 32'h0;
      if (legal && we) model[addr[7:2]] = wdata;
      d_q.push_back(e);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      cyc = -1; mr = 1'b0; mw = 1'b0; ma = '0; mwd = '0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.d_gnt) begin
            cyc = i; mr = bus.mem_read; mw = bus.mem_write; ma = bus.mem_addr; mwd = bus.mem_wdata;
            break;
         end
      end
      bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
      if (cyc < 0) begin
         n_checks++;
         $display("FAIL d_gnt_timeout: no d_gnt within 40 cycles, addr=%h", addr);
         void'(d_q.pop_back());
      end else begin
         @(posedge clk); #1;
      end
      $display("d  req we=%b addr=%h wdata=%h gnt after %0d", we, addr, wdata, cyc);
   endtask

   // Issue one fetch request
   task automatic if_drive(input logic [31:0] addr,
                           output int cyc, output logic mr, output logic mw);
      exp_t e;
      logic legal;
      legal   = (addr[1:0] == 2'b00) && (addr < 32'(MEM_WORDS * 4));
      e.err   = !legal;
      e.rdata = legal ? model[addr[7:2]] : 32'h0;
      if_q.push_back(e);
      bus.if_req = 1'b1; bus.if_addr = addr;
      cyc = -1; mr = 1'b0; mw = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.if_gnt) begin
            cyc = i; mr = bus.mem_read; mw = bus.mem_write;
            break;
         end
      end
      bus.if_req = 1'b0; bus.if_addr = '0;
      if (cyc < 0) begin
         n_checks++;
         $display("FAIL if_gnt_timeout: no if_gnt within 40 cycles, addr=%h", addr);
         void'(if_q.pop_back());
      end else begin
         @(posedge clk); #1;
      end
      $display("if req addr=%h gnt after %0d", addr, cyc);
   endtask

   task automatic test_reset();
      bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if (outs_snapshot() !== 13'h0) $display("FAIL reset_outputs: got %b, expected all 0", outs_snapshot());
      else n_pass++;
      rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      n_checks++;
      if (outs_snapshot() !== 13'h0) $display("FAIL idle_outputs: got %b, expected all 0", outs_snapshot());
      else n_pass++;
   endtask

   task automatic test_single_load();
      int cyc; logic mr, mw; logic [31:0] ma, mwd;
      d_drive(1'b0, 32'd128, 32'h0, cyc, mr, mw, ma, mwd);
      n_checks++;
      if (cyc !== 1) $display("FAIL load_latency: gnt after %0d cycles, expected 1", cyc); else n_pass++;
      n_checks++;
      if ({mr, mw} !== 2'b10) $display("FAIL load_memctl: read/write=%b%b, expected 10", mr, mw); else n_pass++;
      n_checks++;
      if (ma !== 32'd128) $display("FAIL load_memaddr: got %0d, expected 128", ma); else n_pass++;
      n_checks++;
      if (bus.d_rvalid !== 1'b1) $display("FAIL load_rvalid_timing: d_rvalid=%b, expected 1", bus.d_rvalid);
      else n_pass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_store_load();
      int cyc; logic mr, mw; logic [31:0] ma, mwd;
      d_drive(1'b1, 32'd128, 32'h19, cyc, mr, mw, ma, mwd);
      n_checks++;
      if ({mr, mw} !== 2'b01 || ma !== 32'd128 || mwd !== 32'h19)
         $display("FAIL store_memport: rd/wr=%b%b addr=%h wdata=%h, expected 01 80 19", mr, mw, ma, mwd);
      else n_pass++;
      n_checks++;
      if (bus.mem_write !== 1'b0 || bus.d_rvalid !== 1'b1)
         $display("FAIL store_one_cycle: mem_write=%b d_rvalid=%b in RESP, expected 0 1",
                  bus.mem_write, bus.d_rvalid);
      else n_pass++;
      d_drive(1'b0, 32'd128, 32'h0, cyc, mr, mw, ma, mwd);
      n_checks++;
      if (mem[32] !== 32'h19) $display("FAIL store_mem: word 32=%h, expected 00000019", mem[32]);
      else n_pass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_simultaneous();
      int d_cyc, i_cyc, exp_d, exp_i; logic mr, mw, imr, imw; logic [31:0] ma, mwd;
`ifdef ARB_ROUND_ROBIN_EN
      exp_d = 3; exp_i = 1;
`else
      exp_d = 1; exp_i = 3;
`endif
      fork
         d_drive(1'b0, 32'd132, 32'h0, d_cyc, mr, mw, ma, mwd);
         if_drive(32'd0, i_cyc, imr, imw);
      join
      n_checks++;
      if (d_cyc !== exp_d) $display("FAIL tie_d_gnt: after %0d cycles, expected %0d", d_cyc, exp_d);
      else n_pass++;
      n_checks++;
      if (i_cyc !== exp_i) $display("FAIL tie_if_gnt: after %0d cycles, expected %0d", i_cyc, exp_i);
      else n_pass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_illegal();
      int cyc; logic mr, mw; logic [31:0] ma, mwd;
      if_drive(32'h6, cyc, mr, mw);
      n_checks++;
      if (cyc !== 1 || {mr, mw} !== 2'b00)
         $display("FAIL misaligned_if: gnt %0d rd/wr=%b%b, expected 1 00", cyc, mr, mw);
      else n_pass++;
      d_drive(1'b0, 32'd256, 32'h0, cyc, mr, mw, ma, mwd);
      n_checks++;
      if (cyc !== 1 || {mr, mw} !== 2'b00)
         $display("FAIL range_load: gnt %0d rd/wr=%b%b, expected 1 00", cyc, mr, mw);
      else n_pass++;
      d_drive(1'b1, 32'd256, 32'hDEAD, cyc, mr, mw, ma, mwd);
      n_checks++;
      if ({mr, mw} !== 2'b00) $display("FAIL range_store: rd/wr=%b%b, expected 00", mr, mw);
      else n_pass++;
      d_drive(1'b0, 32'd252, 32'h0, cyc, mr, mw, ma, mwd);
      n_checks++;
      if ({mr, mw} !== 2'b10 || ma !== 32'd252)
         $display("FAIL last_word: rd/wr=%b%b addr=%0d, expected 10 252", mr, mw, ma);
      else n_pass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int cyc; logic mr, mw; logic [31:0] ma, mwd; bit got;
      got = 1'b0;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'd136;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (bus.d_gnt) begin got = 1'b1; break; end
      end
      n_checks++;
      if (!got || bus.mem_read !== 1'b1) $display("FAIL midrst_access: gnt=%b mem_read=%b, expected 1 1", got, bus.mem_read);
      else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (outs_snapshot() !== 13'h0) $display("FAIL midrst_async: outputs %b, expected all 0", outs_snapshot());
      else n_pass++;
      bus.d_req = 1'b0; bus.d_addr = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (4) @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL midrst_busy: busy=%b, expected 0", busy); else n_pass++;
      d_drive(1'b0, 32'd140, 32'h0, cyc, mr, mw, ma, mwd);
      n_checks++;
      if (cyc !== 1 || mr !== 1'b1) $display("FAIL midrst_next: gnt %0d mem_read=%b, expected 1 1", cyc, mr);
      else n_pass++;
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_log;
`ifdef ARB_ROUND_ROBIN_EN
      exp_log = 8'b1010_1010;
`else
      exp_log = 8'b0000_1111;
`endif
      log_en = 1'b1;
      fork
         begin
            int c; logic r, w; logic [31:0] a, wd;
            for (int k = 0; k < 4; k++) d_drive(1'b0, 32'(160 + 4 * k), 32'h0, c, r, w, a, wd);
         end
         begin
            int c; logic r, w;
            for (int k = 0; k < 4; k++) if_drive(32'(4 * k), c, r, w);
         end
      join
      repeat (2) @(posedge clk); #1;
      n_checks++;
      if (grant_cnt !== 8 || grant_log !== exp_log)
         $display("FAIL b2b_order: %0d grants log=%b, expected 8 log=%b", grant_cnt, grant_log, exp_log);
      else n_pass++;
      log_en = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < MEM_WORDS; i++) model[i] = init_word(i);
      test_reset();
      test_single_load();
      test_store_load();
      test_simultaneous();
      test_illegal();
      test_reset_mid();
      test_back_to_back();
      for (int i = 0; i < 20 && (if_q.size() != 0 || d_q.size() != 0); i++) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (if_q.size() != 0 || d_q.size() != 0)
         $display("FAIL drain: %0d if / %0d d responses outstanding, expected 0", if_q.size(), d_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
